// File: rtl/encoder_menu_pkg.sv
// Shared definitions for the encoder menu controller and its timing helpers.
//   - Button FSM state encoding (IDLE, PRESSED, HELD)
//   - Rotation direction encoding (NONE, UP, DOWN)
//   - ms_div_tc(): terminal count of the 1 ms divider for a given clock rate
package encoder_menu_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DOWN = 2'd2;

  // Down-counter reload value: the counter spans TC..0, i.e. CLOCK_HZ/1000 cycles.
  function automatic int unsigned ms_div_tc(input int unsigned clock_hz);
    int unsigned div;
    div = clock_hz / 1000;
    return (div > 0) ? div - 1 : 0;
  endfunction

endpackage

// File: rtl/encoder_menu_controller_if.sv
// Encoder-to-menu bus: rotation/button pulses in, selected channel and value bank out.
//   master : encoder front end / consumer side (drives pulses, reads values)
//   slave  : encoder_menu_controller
// Signals:
//   Increment_i, Decrement_i       one-cycle rotation detent pulses
//   ButtonPress_i, ButtonRelease_i one-cycle button edge pulses
//   Channel_o                      selected channel index
//   Value_o                        value of selected channel
//   Values_o                       all values, channel n at [n*WIDTH +: WIDTH]
//   Changed_o                      pulse on any value or channel change
//   LongPress_o                    pulse when a long press qualifies
interface encoder_menu_controller_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      Increment_i;
  logic                      Decrement_i;
  logic                      ButtonPress_i;
  logic                      ButtonRelease_i;
  logic [CH_W-1:0]           Channel_o;
  logic [WIDTH-1:0]          Value_o;
  logic [CHANNELS*WIDTH-1:0] Values_o;
  logic                      Changed_o;
  logic                      LongPress_o;

  modport master (
    output Increment_i, Decrement_i, ButtonPress_i, ButtonRelease_i,
    input  Channel_o, Value_o, Values_o, Changed_o, LongPress_o
  );

  modport slave (
    input  Increment_i, Decrement_i, ButtonPress_i, ButtonRelease_i,
    output Channel_o, Value_o, Values_o, Changed_o, LongPress_o
  );

endinterface

// File: rtl/millisecond_tick.sv
// Free-running 1 ms strobe generator, reusable by any timing block.
// Ports:
//   Clock   system clock, rising edge
//   Reset   asynchronous active-low reset
//   Tick_o  one-cycle strobe every CLOCK_HZ/1000 cycles
// The counter clears on reset, so the first strobe arrives right after reset
// release; consumers must tolerate the first interval being short.
module millisecond_tick
  import encoder_menu_pkg::*;
#(
  parameter int unsigned CLOCK_HZ = 10_000_000
) (
  input  logic Clock,
  input  logic Reset,
  output logic Tick_o
);

  localparam int unsigned TC   = ms_div_tc(CLOCK_HZ);
  localparam int          CNT_W = (TC > 0) ? $clog2(TC + 1) : 1;
  localparam logic [CNT_W-1:0] TC_V = CNT_W'(TC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == '0) ? TC_V : cnt_q - CNT_W'(1);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign Tick_o = (cnt_q == '0);

endmodule

// File: rtl/encoder_menu_controller.sv
// Turns rotary-encoder pulses into a bank of user-adjustable saturating values.
// Rotation edits the selected value, a short press advances the selection and
// a long press restores the selected value to DEFAULT_VALUE.
// Ports:
//   Clock  system clock, rising edge
//   Reset  asynchronous active-low reset
//   bus    encoder_menu_controller_if.slave (pulses in, channel/values out)
// Build option: define ENCODER_ACCEL_EN to enable rotation acceleration
// (same-direction steps closer than ACCEL_WINDOW_MS move by ACCEL_STEP).
//
// Button FSM:
//   state      | meaning
//   ST_IDLE    | button up, waiting for a press
//   ST_PRESSED | button down, counting ms towards a long press
//   ST_HELD    | long press already served, waiting for release
module encoder_menu_controller
  import encoder_menu_pkg::*;
#(
  parameter int unsigned CLOCK_HZ        = 10_000_000,
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned MAX_VALUE       = 100,
  parameter int unsigned DEFAULT_VALUE   = 50,
  parameter int unsigned LONG_PRESS_MS   = 1000,
  parameter int unsigned ACCEL_WINDOW_MS = 20,
  parameter int unsigned ACCEL_STEP      = 10
) (
  input logic Clock,
  input logic Reset,
  encoder_menu_controller_if.slave bus
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int MS_W = $clog2(LONG_PRESS_MS + 1);

  localparam logic [WIDTH-1:0] DEF_V   = WIDTH'(DEFAULT_VALUE);
  localparam logic [WIDTH:0]   MAX_V   = (WIDTH + 1)'(MAX_VALUE);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(CHANNELS - 1);
  localparam logic [MS_W-1:0]  LONG_V  = MS_W'(LONG_PRESS_MS);

  if (CHANNELS < 2 || CHANNELS > 16 || MAX_VALUE >= (1 << WIDTH) ||
      DEFAULT_VALUE > MAX_VALUE || LONG_PRESS_MS < 1 ||
      ACCEL_WINDOW_MS < 1 || ACCEL_STEP < 1 || ACCEL_STEP > MAX_VALUE) begin : g_bad_cfg
    $error("encoder_menu_controller: illegal parameter combination");
  end

  logic [1:0]                     state_q, state_d;
  logic [MS_W-1:0]                ms_q, ms_d;
  logic [CHANNELS-1:0][WIDTH-1:0] vals_q, vals_d;
  logic [CH_W-1:0]                ch_q, ch_d;
  logic                           changed_q, changed_d;
  logic                           long_q, long_d;

  logic             tick;
  logic [1:0]       dir;
  logic [WIDTH:0]   step;
  logic [WIDTH-1:0] cur;
  logic [WIDTH:0]   cur_ext, rot_ext;
  logic [WIDTH-1:0] rot_val;
  logic             short_press, long_press;

  millisecond_tick #(.CLOCK_HZ(CLOCK_HZ)) u_tick (
    .Clock  (Clock),
    .Reset  (Reset),
    .Tick_o (tick)
  );

  always_comb begin
    dir = DIR_NONE;
    if (bus.Increment_i && !bus.Decrement_i)      dir = DIR_UP;
    else if (bus.Decrement_i && !bus.Increment_i) dir = DIR_DOWN;
  end

`ifdef ENCODER_ACCEL_EN
  localparam int GAP_W = $clog2(ACCEL_WINDOW_MS + 1);
  localparam logic [GAP_W-1:0] WIN_V = GAP_W'(ACCEL_WINDOW_MS);

  logic [1:0]       last_dir_q, last_dir_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  always_comb begin
    step = (WIDTH + 1)'(1);
    if (dir != DIR_NONE && dir == last_dir_q && gap_q < WIN_V)
      step = (WIDTH + 1)'(ACCEL_STEP);

    last_dir_d = last_dir_q;
    gap_d      = gap_q;
    if (tick && gap_q != WIN_V) gap_d = gap_q + GAP_W'(1);
    // A step swallowed by a long-press restore does not count as accepted.
    if (dir != DIR_NONE && !long_press) begin
      last_dir_d = dir;
      gap_d      = '0;
    end
    if (short_press) last_dir_d = DIR_NONE;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      last_dir_q <= DIR_NONE;
      gap_q      <= '0;
    end else begin
      last_dir_q <= last_dir_d;
      gap_q      <= gap_d;
    end
  end
`else
  assign step = (WIDTH + 1)'(1);
`endif

  // Saturating rotation in WIDTH+1 bits so the sum cannot wrap before clamping.
  assign cur     = vals_q[ch_q];
  assign cur_ext = {1'b0, cur};

  always_comb begin
    rot_ext = cur_ext;
    if (dir == DIR_UP)
      rot_ext = ((cur_ext + step) > MAX_V) ? MAX_V : cur_ext + step;
    else if (dir == DIR_DOWN)
      rot_ext = (cur_ext < step) ? '0 : cur_ext - step;
  end
  assign rot_val = rot_ext[WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    ms_d        = ms_q;
    short_press = 1'b0;
    long_press  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ButtonPress_i) begin
          state_d = ST_PRESSED;
          ms_d    = LONG_V;
        end
      end
      ST_PRESSED: begin
        if (bus.ButtonRelease_i) begin
          short_press = 1'b1;
          state_d     = ST_IDLE;
        end else if (tick) begin
          if (ms_q <= MS_W'(1)) begin
            long_press = 1'b1;
            state_d    = ST_HELD;
            ms_d       = '0;
          end else begin
            ms_d = ms_q - MS_W'(1);
          end
        end
      end
      ST_HELD: begin
        if (bus.ButtonRelease_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Restore wins over a same-cycle step; a step coinciding with a short press
  // lands on the channel selected before the advance.
  always_comb begin
    vals_d    = vals_q;
    ch_d      = ch_q;
    changed_d = 1'b0;
    long_d    = long_press;
    if (long_press) begin
      vals_d[ch_q] = DEF_V;
      changed_d    = 1'b1;
    end else if (rot_val != cur) begin
      vals_d[ch_q] = rot_val;
      changed_d    = 1'b1;
    end
    if (short_press) begin
      ch_d      = (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);
      changed_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      ms_q      <= '0;
      vals_q    <= {CHANNELS{DEF_V}};
      ch_q      <= '0;
      changed_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ms_q      <= ms_d;
      vals_q    <= vals_d;
      ch_q      <= ch_d;
      changed_q <= changed_d;
      long_q    <= long_d;
    end
  end

  assign bus.Channel_o   = ch_q;
  assign bus.Value_o     = cur;
  assign bus.Values_o    = vals_q;
  assign bus.Changed_o   = changed_q;
  assign bus.LongPress_o = long_q;

endmodule

// File: tb/tb_encoder_menu_controller.sv
// Directed bench for encoder_menu_controller: CLOCK_HZ=10_000 (1 ms = 10 cycles),
// LONG_PRESS_MS=5, other parameters at their defaults.
module tb_encoder_menu_controller;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;
  int chg_cnt = 0;
  int lp_cnt  = 0;
  int cyc_cnt = 0;
  int n_lp = 0;
  int lp_press_edge = 0;

`ifdef ENCODER_ACCEL_EN
  // Space single steps beyond the acceleration window so they stay +/-1.
  localparam int ROT_GAP = 210;
`else
  localparam int ROT_GAP = 0;
`endif

  encoder_menu_controller_if #(.CHANNELS(4), .WIDTH(8)) bus ();

  encoder_menu_controller #(
    .CLOCK_HZ        (10_000),
    .CHANNELS        (4),
    .WIDTH           (8),
    .MAX_VALUE       (100),
    .DEFAULT_VALUE   (50),
    .LONG_PRESS_MS   (5),
    .ACCEL_WINDOW_MS (20),
    .ACCEL_STEP      (10)
  ) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (bus.Changed_o === 1'b1)   chg_cnt <= chg_cnt + 1;
    if (bus.LongPress_o === 1'b1) lp_cnt  <= lp_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the given pulses for exactly one sampling edge; returns 1 ns after it.
  task automatic drive(input logic inc, input logic dec, input logic prs, input logic rel);
    bus.Increment_i     = inc;
    bus.Decrement_i     = dec;
    bus.ButtonPress_i   = prs;
    bus.ButtonRelease_i = rel;
    cyc(1);
    bus.Increment_i     = 1'b0;
    bus.Decrement_i     = 1'b0;
    bus.ButtonPress_i   = 1'b0;
    bus.ButtonRelease_i = 1'b0;
  endtask

  task automatic rot(input logic inc, input logic dec);
    cyc(ROT_GAP);
    drive(inc, dec, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    checks++; if (bus.Values_o !== 32'h32323232) begin errors++; $display("FAIL reset_values: got %h expected %h", bus.Values_o, 32'h32323232); end
    checks++; if (bus.Channel_o !== 2'd0) begin errors++; $display("FAIL reset_channel: got %0d expected 0", bus.Channel_o); end
    checks++; if (bus.Changed_o !== 1'b0 || bus.LongPress_o !== 1'b0) begin errors++; $display("FAIL reset_pulses: got changed=%b long=%b expected 0 0", bus.Changed_o, bus.LongPress_o); end
    rst_n = 1'b1;
    cyc(2);
    checks++; if (bus.Value_o !== 8'd50) begin errors++; $display("FAIL reset_value_after_release: got %0d expected 50", bus.Value_o); end
  endtask

  task automatic test_rotation();
    int c0;
    c0 = chg_cnt;
    for (int i = 1; i <= 3; i++) begin
      rot(1'b1, 1'b0);
      checks++; if (bus.Value_o !== 8'(50 + i) || bus.Changed_o !== 1'b1) begin errors++; $display("FAIL inc_step%0d: got value=%0d changed=%b expected %0d 1", i, bus.Value_o, bus.Changed_o, 50 + i); end
    end
    cyc(1);
    checks++; if (chg_cnt - c0 !== 3) begin errors++; $display("FAIL inc_changed_count: got %0d expected 3", chg_cnt - c0); end
    c0 = chg_cnt;
    for (int i = 0; i < 60; i++) rot(1'b1, 1'b0);
    cyc(1);
    checks++; if (bus.Value_o !== 8'd100) begin errors++; $display("FAIL sat_max_value: got %0d expected 100", bus.Value_o); end
    checks++; if (chg_cnt - c0 !== 47) begin errors++; $display("FAIL sat_max_changed_count: got %0d expected 47", chg_cnt - c0); end
    for (int i = 0; i < 100; i++) rot(1'b0, 1'b1);
    cyc(1);
    checks++; if (bus.Value_o !== 8'd0) begin errors++; $display("FAIL dec_to_zero: got %0d expected 0", bus.Value_o); end
    c0 = chg_cnt;
    rot(1'b0, 1'b1);
    checks++; if (bus.Value_o !== 8'd0 || bus.Changed_o !== 1'b0) begin errors++; $display("FAIL sat_min: got value=%0d changed=%b expected 0 0", bus.Value_o, bus.Changed_o); end
    cyc(1);
    checks++; if (chg_cnt - c0 !== 0) begin errors++; $display("FAIL sat_min_changed_count: got %0d expected 0", chg_cnt - c0); end
  endtask

  task automatic test_short_press();
    int c0;
    logic [1:0] exp_ch;
    for (int k = 1; k <= 4; k++) begin
      c0 = chg_cnt;
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(19);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      exp_ch = 2'(k % 4);
      checks++; if (bus.Channel_o !== exp_ch || bus.Changed_o !== 1'b1) begin errors++; $display("FAIL short_press%0d: got ch=%0d changed=%b expected %0d 1", k, bus.Channel_o, bus.Changed_o, exp_ch); end
      cyc(1);
      checks++; if (chg_cnt - c0 !== 1) begin errors++; $display("FAIL short_press%0d_changed_count: got %0d expected 1", k, chg_cnt - c0); end
    end
  endtask

  task automatic test_long_press();
    int lp0;
    logic [7:0] seen_val;
    logic seen_chg;
    seen_val = '0;
    seen_chg = 1'b0;
    for (int i = 0; i < 80; i++) rot(1'b1, 1'b0);
    checks++; if (bus.Value_o !== 8'd80) begin errors++; $display("FAIL long_setup: got %0d expected 80", bus.Value_o); end
    cyc(1);
    lp0 = lp_cnt;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    lp_press_edge = cyc_cnt;
    n_lp = 0;
    for (int i = 1; i <= 60; i++) begin
      cyc(1);
      if (bus.LongPress_o === 1'b1 && n_lp == 0) begin
        n_lp     = i;
        seen_val = bus.Value_o;
        seen_chg = bus.Changed_o;
      end
    end
    checks++; if (n_lp < 41 || n_lp > 50) begin errors++; $display("FAIL long_timing: got %0d cycles expected 41..50", n_lp); end
    checks++; if (seen_val !== 8'd50 || seen_chg !== 1'b1) begin errors++; $display("FAIL long_restore: got value=%0d changed=%b expected 50 1", seen_val, seen_chg); end
    checks++; if (lp_cnt - lp0 !== 1) begin errors++; $display("FAIL long_pulse_count: got %0d expected 1", lp_cnt - lp0); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.Channel_o !== 2'd0 || bus.Value_o !== 8'd50 || bus.Changed_o !== 1'b0) begin errors++; $display("FAIL long_release: got ch=%0d value=%0d changed=%b expected 0 50 0", bus.Channel_o, bus.Value_o, bus.Changed_o); end
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.Value_o !== 8'd50 || bus.Changed_o !== 1'b0) begin errors++; $display("FAIL both_dirs: got value=%0d changed=%b expected 50 0", bus.Value_o, bus.Changed_o); end
    for (int i = 0; i < 5; i++) rot(1'b1, 1'b0);
    checks++; if (bus.Value_o !== 8'd55) begin errors++; $display("FAIL prio_setup: got %0d expected 55", bus.Value_o); end
    if (n_lp == 0) n_lp = 45;
    // Press on the same divider phase as before so qualification lands n_lp edges later.
    for (int i = 0; i < 10; i++) begin
      if (((cyc_cnt + 1) % 10) == (lp_press_edge % 10)) break;
      cyc(1);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(n_lp - 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.LongPress_o !== 1'b1 || bus.Value_o !== 8'd50) begin errors++; $display("FAIL prio_long_over_inc: got long=%b value=%0d expected 1 50", bus.LongPress_o, bus.Value_o); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_press();
    int c0, lp0;
    for (int i = 0; i < 3; i++) rot(1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(9);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) rot(1'b1, 1'b0);
    cyc(1);
    checks++; if (bus.Values_o !== 32'h32323435 || bus.Channel_o !== 2'd1) begin errors++; $display("FAIL rst_setup: got %h ch=%0d expected 32323435 1", bus.Values_o, bus.Channel_o); end
    c0  = chg_cnt;
    lp0 = lp_cnt;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(29);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.Values_o !== 32'h32323232 || bus.Channel_o !== 2'd0) begin errors++; $display("FAIL rst_mid_press: got %h ch=%0d expected 32323232 0", bus.Values_o, bus.Channel_o); end
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.Channel_o !== 2'd0 || bus.Changed_o !== 1'b0) begin errors++; $display("FAIL rst_release_ignored: got ch=%0d changed=%b expected 0 0", bus.Channel_o, bus.Changed_o); end
    cyc(60);
    checks++; if (chg_cnt - c0 !== 0 || lp_cnt - lp0 !== 0) begin errors++; $display("FAIL rst_no_pulses: got changed=%0d long=%0d expected 0 0", chg_cnt - c0, lp_cnt - lp0); end
  endtask

  task automatic test_accel();
    int exp_a[6];
    int gap_a[6];
    logic inc_a[6];
`ifdef ENCODER_ACCEL_EN
    exp_a = '{51, 61, 71, 70, 71, 72};
`else
    exp_a = '{51, 52, 53, 52, 53, 54};
`endif
    gap_a = '{0, 10, 10, 10, 300, 300};
    inc_a = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      if (gap_a[k] > 0) cyc(gap_a[k] - 1);
      drive(inc_a[k], !inc_a[k], 1'b0, 1'b0);
      checks++; if (bus.Value_o !== 8'(exp_a[k])) begin errors++; $display("FAIL accel_step%0d: got %0d expected %0d", k, bus.Value_o, exp_a[k]); end
    end
  endtask

  initial begin
    bus.Increment_i     = 1'b0;
    bus.Decrement_i     = 1'b0;
    bus.ButtonPress_i   = 1'b0;
    bus.ButtonRelease_i = 1'b0;
    test_reset();
    test_rotation();
    test_short_press();
    test_long_press();
    test_priority();
    test_reset_mid_press();
    test_accel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
